rsa_modexp_serial: RTL and testbench
====================================

Name: rsa_modexp_serial

Overview:
- Parametrised successor to the 32-bit RSA exponentiation core. Computes C = M^E mod N at any operand width using a bit-serial radix-2 Montgomery multiplier, so no N_INV input and no WIDTH x WIDTH multiplier are needed.
- Sits behind the Wishbone RSA register slave in place of the old core.
- Adds a start/busy handshake, input latching, leading-zero exponent skip, and error detection.

Parameters:
- WIDTH, 64: modulus/operand width in bits (>= 8).
- E_BITS, 64: exponent width in bits (>= 1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted only when busy=0.
- M  in  WIDTH  message; must satisfy M < N.
- E  in  E_BITS  exponent.
- N  in  WIDTH  modulus; must be odd and > 1.
- R2_MOD_N  in  WIDTH  (2^WIDTH)^2 mod N, precomputed by software.
- C  out  WIDTH  result; held until the next accepted start.
- busy  out  1  high from the cycle after acceptance until done.
- done  out  1  single-cycle pulse when C/err are valid.
- err  out  1  set with done on invalid input; held until the next accepted start.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; C=0, busy=0, done=0, err=0; all internal registers cleared. Reset mid-operation aborts immediately with no done pulse.
- Acceptance: start=1 while busy=0 at a clk edge. M, E, N and R2_MOD_N are latched, so later input changes have no effect. start while busy=1 is ignored and not queued.
- Error checks (in the CHECK cycle after acceptance): N even, N<=1, or M>=N → err=1, C=0, done pulse, back to IDLE. Total 2 cycles from acceptance to done.
- E==0 (valid N, M): C=1, err=0, done in the CHECK cycle (2 cycles).
- States: IDLE → CHECK → CONV_M → CONV_R → SQR → (MUL if current E bit = 1) → next bit … → FINAL → IDLE.
  - CHECK also sets bit index L-1, where L = position of the highest set E bit + 1 (priority encoder, single cycle). Leading zeros cost no cycles.
- Montgomery op mont(A,B) = A*B*2^-WIDTH mod N:
  - 1 LOAD cycle: S=0, load A shift register and B.
  - WIDTH iteration cycles: S = S + a_i*B; if S odd then S += N; S >>= 1. S is WIDTH+2 bits wide.
  - 1 correction cycle: if S >= N then S -= N.
  - Total WIDTH+2 cycles per op.
- Operation sequence:
  - CONV_M: Mb = mont(M, R2_MOD_N).
  - CONV_R: Rb = mont(1, R2_MOD_N).
  - Loop over bits L-1..0: Rb = mont(Rb, Rb); if the bit is set, Rb = mont(Rb, Mb).
  - FINAL: C = mont(Rb, 1).
- Latency for valid E != 0: acceptance to done = 1 + (WIDTH+2)*(3 + L + P) cycles, where P = popcount(E).
  - done pulses on the cycle C updates; busy falls in that same cycle.
  - A new start is accepted the cycle after done.
- Intermediates stay < N throughout. C < N is guaranteed.

Optional Feature:
- Macro: RSA_MODEXP_CYCLE_CNT_EN.
- Defined: adds output port cycle_cnt [31:0].
  - Cleared on acceptance; increments every cycle while busy=1; freezes at done; saturates at 0xFFFFFFFF; reset value 0.
  - After a valid E != 0 operation it equals the latency formula minus 1.
- Undefined: port and counter are absent; behaviour otherwise identical.

Test Plan:
- WIDTH=8, E_BITS=8; M=5, E=3, N=13, R2_MOD_N=3 → C=8, err=0, done exactly 71 cycles after acceptance (L=2, P=2). busy=1 throughout; a second start pulse mid-run is ignored.
- WIDTH=8; N=12 (even), M=5, E=3 → err=1, C=0, done 2 cycles after acceptance. Then a valid run (M=5, E=3, N=13, R2_MOD_N=3) → err clears, C=8.
- WIDTH=8; M=7, E=0, N=13 → C=1, err=0, done 2 cycles after acceptance. M=13, N=13 → err=1.
- WIDTH=32, E_BITS=32; M=2, E=10, N=1000003, R2_MOD_N taken from the bench model → C=1024. Also E=0x00000001 (L=1, P=1) → C=2, done at 1 + 34*5 = 171 cycles.
- Reset mid-operation: assert rst_n=0 during SQR → C=0, busy=0, done never pulses. A new run after release gives the correct result.
- Randomised check against a reference model (WIDTH=16, 200 odd N, M<N, random E) → every C matches and every latency matches the formula; with RSA_MODEXP_CYCLE_CNT_EN, cycle_cnt = latency - 1.

Source files
------------

// File: rtl/rsa_modexp_serial.sv
// C = M^E mod N via bit-serial radix-2 Montgomery; 2 cycles on error/E==0, else 1+(WIDTH+2)*(3+L+popcount(E)).
// start is ignored while busy (not queued); RSA_MODEXP_CYCLE_CNT_EN adds a saturating busy-cycle counter port.
module rsa_modexp_serial #(
  parameter int WIDTH  = 64,
  parameter int E_BITS = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WIDTH-1:0]  M,
  input  logic [E_BITS-1:0] E,
  input  logic [WIDTH-1:0]  N,
  input  logic [WIDTH-1:0]  R2_MOD_N,
  output logic [WIDTH-1:0]  C,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef RSA_MODEXP_CYCLE_CNT_EN
  ,
  output logic [31:0]       cycle_cnt
`endif
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam int BW = (E_BITS > 1) ? $clog2(E_BITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH + 1);
  localparam logic [CW-1:0] ITER = CW'(WIDTH);

  typedef enum logic [2:0] {IDLE, CHECK, CONV_M, CONV_R, SQR, MUL, FINAL} state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  m_r, n_r, r2_r, mb, rb, a_sh, b_r;
  logic [E_BITS-1:0] e_r;
  logic [WIDTH+1:0]  s;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     bit_idx, hi_idx;
  logic              quick, quick_err;

  logic              accept, fin, op_last, in_err, e_zero, bit_set, adv_bit;
  logic [WIDTH-1:0]  op_a, op_b, res;
  logic [WIDTH+1:0]  t_add, t_red, s_nxt, s_cor;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    accept    = (state == IDLE) && start;
    op_last   = (cnt == LAST);
    in_err    = !n_r[0] || (n_r <= WIDTH'(1)) || (m_r >= n_r);
    e_zero    = (e_r == '0);
    bit_set   = e_r[bit_idx];
    fin       = (state == FINAL) && (quick || op_last);
    adv_bit   = op_last && (bit_idx != '0) &&
                (((state == SQR) && !bit_set) || (state == MUL));
    hi_idx    = '0;
    for (int i = 0; i < E_BITS; i++)
      if (e_r[i]) hi_idx = BW'(i);
    op_a = rb;
    op_b = rb;
    case (state)
      CONV_M: begin op_a = m_r;        op_b = r2_r;       end
      CONV_R: begin op_a = WIDTH'(1);  op_b = r2_r;       end
      MUL:    begin op_a = rb;         op_b = mb;         end
      FINAL:  begin op_a = rb;         op_b = WIDTH'(1);  end
      default: ;
    endcase
    case (state)
      IDLE:   if (start) state_nxt = CHECK;
      CHECK:  state_nxt = (in_err || e_zero) ? FINAL : CONV_M;
      CONV_M: if (op_last) state_nxt = CONV_R;
      CONV_R: if (op_last) state_nxt = SQR;
      SQR:    if (op_last) state_nxt = bit_set ? MUL : ((bit_idx == '0) ? FINAL : SQR);
      MUL:    if (op_last) state_nxt = (bit_idx == '0) ? FINAL : SQR;
      FINAL:  if (quick || op_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One Montgomery step; S stays below 2N so WIDTH+2 bits never overflow.
  always_comb begin
    t_add = s + (a_sh[0] ? {2'b00, b_r} : '0);
    t_red = t_add + (t_add[0] ? {2'b00, n_r} : '0);
    s_nxt = {1'b0, t_red[WIDTH+1:1]};
    s_cor = (s >= {2'b00, n_r}) ? (s - {2'b00, n_r}) : s;
    res   = s_cor[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_r <= '0; n_r <= '0; r2_r <= '0; e_r <= '0;
      mb <= '0; rb <= '0; a_sh <= '0; b_r <= '0; s <= '0;
      cnt <= '0; bit_idx <= '0; quick <= 1'b0; quick_err <= 1'b0;
      C <= '0; done <= 1'b0; err <= 1'b0;
    end else begin
      done <= fin;
      if (accept) begin
        m_r <= M; e_r <= E; n_r <= N; r2_r <= R2_MOD_N;
        C <= '0; err <= 1'b0;
      end
      if (state == CHECK) begin
        bit_idx   <= hi_idx;
        quick     <= in_err || e_zero;
        quick_err <= in_err;
        cnt       <= '0;
      end else if (state == FINAL && quick) begin
        C   <= quick_err ? '0 : WIDTH'(1);
        err <= quick_err;
      end else if (state != IDLE) begin
        if (cnt == '0) begin
          s    <= '0;
          a_sh <= op_a;
          b_r  <= op_b;
          cnt  <= cnt + 1'b1;
        end else if (cnt <= ITER) begin
          s    <= s_nxt;
          a_sh <= a_sh >> 1;
          cnt  <= cnt + 1'b1;
        end else begin
          cnt <= '0;
          case (state)
            CONV_M:  mb <= res;
            FINAL:   begin C <= res; err <= 1'b0; end
            default: rb <= res;
          endcase
          if (adv_bit) bit_idx <= bit_idx - 1'b1;
        end
      end
    end
  end

`ifdef RSA_MODEXP_CYCLE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   cycle_cnt <= '0;
    else if (accept)                              cycle_cnt <= '0;
    else if (busy && !fin && (cycle_cnt != '1))   cycle_cnt <= cycle_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_rsa_modexp_serial.sv
// Bench for rsa_modexp_serial at WIDTH 8, 16 and 32 against an arithmetic modexp reference.
module tb_rsa_modexp_serial;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic [31:0] m_i, e_i, n_i, r2_i;
  int sel_r;
  int total = 0;
  int bad = 0;

  logic [7:0]  c8;
  logic [15:0] c16;
  logic [31:0] c32;
  logic busy8, done8, err8, busy16, done16, err16, busy32, done32, err32;
  logic [31:0] c_o, cnt_o;
  logic busy_o, done_o, err_o;
`ifdef RSA_MODEXP_CYCLE_CNT_EN
  logic [31:0] cnt8, cnt16, cnt32;
`endif

  always #5 clk = ~clk;

  rsa_modexp_serial #(.WIDTH(8), .E_BITS(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start && sel_r == 0),
    .M(m_i[7:0]), .E(e_i[7:0]), .N(n_i[7:0]), .R2_MOD_N(r2_i[7:0]),
    .C(c8), .busy(busy8), .done(done8), .err(err8)
`ifdef RSA_MODEXP_CYCLE_CNT_EN
    , .cycle_cnt(cnt8)
`endif
  );

  rsa_modexp_serial #(.WIDTH(16), .E_BITS(16)) u16 (
    .clk(clk), .rst_n(rst_n), .start(start && sel_r == 1),
    .M(m_i[15:0]), .E(e_i[15:0]), .N(n_i[15:0]), .R2_MOD_N(r2_i[15:0]),
    .C(c16), .busy(busy16), .done(done16), .err(err16)
`ifdef RSA_MODEXP_CYCLE_CNT_EN
    , .cycle_cnt(cnt16)
`endif
  );

  rsa_modexp_serial #(.WIDTH(32), .E_BITS(32)) u32 (
    .clk(clk), .rst_n(rst_n), .start(start && sel_r == 2),
    .M(m_i), .E(e_i), .N(n_i), .R2_MOD_N(r2_i),
    .C(c32), .busy(busy32), .done(done32), .err(err32)
`ifdef RSA_MODEXP_CYCLE_CNT_EN
    , .cycle_cnt(cnt32)
`endif
  );

  always_comb begin
    c_o = '0; busy_o = 1'b0; done_o = 1'b0; err_o = 1'b0; cnt_o = '0;
    case (sel_r)
      0: begin c_o = {24'd0, c8};  busy_o = busy8;  done_o = done8;  err_o = err8;  end
      1: begin c_o = {16'd0, c16}; busy_o = busy16; done_o = done16; err_o = err16; end
      default: begin c_o = c32;    busy_o = busy32; done_o = done32; err_o = err32; end
    endcase
`ifdef RSA_MODEXP_CYCLE_CNT_EN
    case (sel_r)
      0: cnt_o = cnt8;
      1: cnt_o = cnt16;
      default: cnt_o = cnt32;
    endcase
`endif
  end

  // Reference: plain square-and-multiply with 64-bit modular arithmetic.
  function automatic logic [31:0] ref_pow(input logic [63:0] m, input logic [63:0] e, input logic [63:0] n);
    logic [63:0] r;
    r = 64'd1 % n;
    for (int i = 31; i >= 0; i--) begin
      r = (r * r) % n;
      if (e[i]) r = (r * (m % n)) % n;
    end
    return r[31:0];
  endfunction

  function automatic logic [31:0] ref_r2(input int w, input logic [63:0] n);
    logic [63:0] r;
    r = (64'd1 << w) % n;
    r = (r * r) % n;
    return r[31:0];
  endfunction

  function automatic int ref_lat(input int w, input logic [31:0] e);
    int l, p;
    l = 0; p = 0;
    for (int i = 0; i < 32; i++) if (e[i]) begin l = i + 1; p++; end
    if (e == 0) return 2;
    return 1 + (w + 2) * (3 + l + p);
  endfunction

  task automatic run_op(input int sel, input logic [31:0] m, input logic [31:0] e,
                        input logic [31:0] n, input logic [31:0] r2, input int extra_at,
                        output logic [31:0] c, output logic er, output int lat,
                        output logic busy_ok, output logic [31:0] cc);
    logic got;
    int k;
    k = 0;
    @(negedge clk);
    sel_r = sel;
    while (busy_o && k < 2000) begin @(negedge clk); k++; end
    m_i = m; e_i = e; n_i = n; r2_i = r2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    m_i = $urandom; e_i = $urandom; n_i = $urandom; r2_i = $urandom;
    lat = 0; busy_ok = 1'b1; got = 1'b0;
    while (!got && lat < 20000) begin
      @(posedge clk); #1;
      lat++;
      if (done_o) begin
        got = 1'b1;
        if (busy_o !== 1'b0) busy_ok = 1'b0;
      end else begin
        if (busy_o !== 1'b1) busy_ok = 1'b0;
        start = (lat == extra_at);
      end
    end
    start = 1'b0;
    c = c_o; er = err_o; cc = cnt_o;
    total++;
    if (!got) begin
      bad++;
      $display("FAIL op_timeout sel=%0d waited=%0d cycles without done", sel, lat);
    end
    @(posedge clk); #1;
    total++;
    if (done_o !== 1'b0) begin
      bad++;
      $display("FAIL done_pulse_width sel=%0d done=%b want 0", sel, done_o);
    end
  endtask

  task automatic test_reset();
    total++;
    if ({c8, busy8, done8, err8} !== 11'd0 || {c16, busy16, done16, err16} !== 19'd0 ||
        {c32, busy32, done32, err32} !== 35'd0) begin
      bad++;
      $display("FAIL reset_outputs c8=%h c16=%h c32=%h busy=%b%b%b want all zero", c8, c16, c32, busy8, busy16, busy32);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({busy8, done8, busy16, done16, busy32, done32} !== 6'd0) begin
      bad++;
      $display("FAIL reset_idle busy/done=%b want 0", {busy8, done8, busy16, done16, busy32, done32});
    end
  endtask

  task automatic test_basic8();
    logic [31:0] c, cc; logic er, bok; int lat;
    run_op(0, 5, 3, 13, 3, 30, c, er, lat, bok, cc);
    total++; if (c !== 32'd8) begin bad++; $display("FAIL basic8_c got=%0d want=8", c); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL basic8_err got=%b want=0", er); end
    total++; if (lat !== 71) begin bad++; $display("FAIL basic8_latency got=%0d want=71", lat); end
    total++; if (bok !== 1'b1) begin bad++; $display("FAIL basic8_busy got=%b want=1", bok); end
`ifdef RSA_MODEXP_CYCLE_CNT_EN
    total++; if (cc !== 32'd70) begin bad++; $display("FAIL basic8_cycle_cnt got=%0d want=70", cc); end
`endif
  endtask

  task automatic test_errors();
    logic [31:0] c, cc; logic er, bok; int lat;
    run_op(0, 5, 3, 12, 3, -1, c, er, lat, bok, cc);
    total++; if (er !== 1'b1 || c !== 32'd0 || lat !== 2) begin
      bad++; $display("FAIL err_even_n err=%b c=%0d lat=%0d want 1/0/2", er, c, lat); end
    run_op(0, 5, 3, 13, 3, -1, c, er, lat, bok, cc);
    total++; if (er !== 1'b0 || c !== 32'd8) begin
      bad++; $display("FAIL err_recover err=%b c=%0d want 0/8", er, c); end
    run_op(0, 7, 0, 13, 3, -1, c, er, lat, bok, cc);
    total++; if (er !== 1'b0 || c !== 32'd1 || lat !== 2) begin
      bad++; $display("FAIL e_zero err=%b c=%0d lat=%0d want 0/1/2", er, c, lat); end
    run_op(0, 13, 3, 13, 3, -1, c, er, lat, bok, cc);
    total++; if (er !== 1'b1 || c !== 32'd0 || lat !== 2) begin
      bad++; $display("FAIL err_m_ge_n err=%b c=%0d lat=%0d want 1/0/2", er, c, lat); end
    run_op(0, 0, 3, 1, 0, -1, c, er, lat, bok, cc);
    total++; if (er !== 1'b1 || c !== 32'd0 || lat !== 2) begin
      bad++; $display("FAIL err_n_one err=%b c=%0d lat=%0d want 1/0/2", er, c, lat); end
  endtask

  task automatic test_wide32();
    logic [31:0] c, cc, r2; logic er, bok; int lat;
    r2 = ref_r2(32, 64'd1000003);
    run_op(2, 2, 10, 1000003, r2, -1, c, er, lat, bok, cc);
    total++; if (c !== 32'd1024 || er !== 1'b0) begin
      bad++; $display("FAIL wide32_pow10 c=%0d err=%b want 1024/0", c, er); end
    total++; if (lat !== ref_lat(32, 10)) begin
      bad++; $display("FAIL wide32_pow10_lat got=%0d want=%0d", lat, ref_lat(32, 10)); end
    run_op(2, 2, 1, 1000003, r2, -1, c, er, lat, bok, cc);
    total++; if (c !== 32'd2 || lat !== 171) begin
      bad++; $display("FAIL wide32_pow1 c=%0d lat=%0d want 2/171", c, lat); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] c, cc; logic er, bok, saw; int lat;
    @(negedge clk);
    sel_r = 0; m_i = 5; e_i = 3; n_i = 13; r2_i = 3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    total++; if (busy8 !== 1'b1) begin bad++; $display("FAIL midrst_busy_before got=%b want=1", busy8); end
    rst_n = 1'b0; #1;
    total++; if (c8 !== 8'd0 || busy8 !== 1'b0 || done8 !== 1'b0 || err8 !== 1'b0) begin
      bad++; $display("FAIL midrst_clear c=%0d busy=%b done=%b err=%b want all 0", c8, busy8, done8, err8); end
    saw = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (done8) saw = 1'b1; end
    @(negedge clk); rst_n = 1'b1;
    repeat (80) begin @(posedge clk); #1; if (done8 || busy8) saw = 1'b1; end
    total++; if (saw !== 1'b0) begin bad++; $display("FAIL midrst_no_done saw=%b want 0", saw); end
    run_op(0, 5, 3, 13, 3, -1, c, er, lat, bok, cc);
    total++; if (c !== 32'd8 || er !== 1'b0 || lat !== 71) begin
      bad++; $display("FAIL midrst_rerun c=%0d err=%b lat=%0d want 8/0/71", c, er, lat); end
  endtask

  task automatic test_random16();
    logic [31:0] c, cc, m, e, n, want_c; logic er, bok, want_err; int lat, want_lat, pick;
    for (int it = 0; it < 200; it++) begin
      pick = $urandom_range(0, 9);
      n = ($urandom_range(3, 65535)) | 32'd1;
      if (pick == 2) n = $urandom_range(2, 65535) & 32'hFFFE;
      m = $urandom % n;
      if (pick == 0)      e = $urandom & 32'hFFFF;
      else if (pick == 1) e = 0;
      else                e = $urandom_range(1, 63);
      want_err = (n[0] == 1'b0) || (n <= 1) || (m >= n);
      want_c   = want_err ? 32'd0 : ref_pow({32'd0, m}, {32'd0, e}, {32'd0, n});
      want_lat = want_err ? 2 : ref_lat(16, e);
      run_op(1, m, e, n, ref_r2(16, {32'd0, n}), -1, c, er, lat, bok, cc);
      total++; if (c !== want_c || er !== want_err) begin
        bad++; $display("FAIL rand16_result it=%0d m=%0d e=%0d n=%0d c=%0d err=%b want %0d/%b", it, m, e, n, c, er, want_c, want_err); end
      total++; if (lat !== want_lat || bok !== 1'b1) begin
        bad++; $display("FAIL rand16_latency it=%0d e=%0d lat=%0d busy_ok=%b want %0d/1", it, e, lat, bok, want_lat); end
`ifdef RSA_MODEXP_CYCLE_CNT_EN
      if (!want_err && e != 0) begin
        total++; if (cc !== 32'(want_lat - 1)) begin
          bad++; $display("FAIL rand16_cycle_cnt it=%0d got=%0d want=%0d", it, cc, want_lat - 1); end
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] c, cc, m, e, n; logic er, bok; int lat;
    for (int it = 0; it < 5; it++) begin
      n = $urandom | 32'h8000_0001;
      m = $urandom % n;
      e = $urandom_range(1, 255);
      run_op(2, m, e, n, ref_r2(32, {32'd0, n}), -1, c, er, lat, bok, cc);
      total++; if (c !== ref_pow({32'd0, m}, {32'd0, e}, {32'd0, n}) || er !== 1'b0 || lat !== ref_lat(32, e)) begin
        bad++; $display("FAIL b2b32 it=%0d c=%h err=%b lat=%0d want %h/0/%0d", it, c, er, lat,
                        ref_pow({32'd0, m}, {32'd0, e}, {32'd0, n}), ref_lat(32, e)); end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; sel_r = 0;
    m_i = '0; e_i = '0; n_i = '0; r2_i = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_basic8();
    test_errors();
    test_wide32();
    test_reset_mid();
    test_random16();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
